// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU port, DMA port and data-memory bus shared by dmem_port_arbiter.
// slave = arbiter side, master = requesters plus the memory.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake semantics:
  // - CPU: an access presented with cpu_req is taken in the same cycle unless
  //   cpu_stall is high, in which case it is re-presented unchanged.
  // - DMA: dma_req and its fields stay stable until a cycle with dma_gnt high;
  //   that cycle is the transfer.
  // - Reads: the read returns exactly one cycle after the transfer, on the
  //   owner's rvalid. Writes return nothing.
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_wren;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data_dmem;
  logic              wren_dmem;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_wren, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output address_dmem, data_dmem, wren_dmem,
    input  q_dmem
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_wren, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  address_dmem, data_dmem, wren_dmem,
    output q_dmem
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port dmem arbiter between the CPU MEM stage and a DMA requester.
// CPU has priority; the DMA is forced through after MAX_WAIT denied cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  dmem_port_arbiter_if.slave               bus,
  output logic [$clog2(MAX_WAIT+1)-1:0]    wait_cnt,
  output logic [1:0]                       rsp_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e grant;
  owner_e rsp_owner;
  owner_e rsp_next;
  logic   dma_forced;

  assign dma_forced = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Reset masks every grant so no write reaches the memory during reset.
  always_comb begin
    grant = OWN_NONE;
    if (!reset) begin
      if (bus.dma_req && dma_forced) grant = OWN_DMA;
      else if (bus.cpu_req)          grant = OWN_CPU;
      else if (bus.dma_req)          grant = OWN_DMA;
    end
  end

  always_comb begin
    bus.address_dmem = bus.cpu_addr;
    bus.data_dmem    = bus.cpu_wdata;
    bus.wren_dmem    = 1'b0;
    case (grant)
      OWN_CPU: begin
        bus.wren_dmem = bus.cpu_wren;
      end
      OWN_DMA: begin
        bus.address_dmem = bus.dma_addr;
        bus.data_dmem    = bus.dma_wdata;
        bus.wren_dmem    = bus.dma_wren;
      end
      default: ;
    endcase
  end

  assign bus.dma_gnt   = (grant == OWN_DMA);
  assign bus.cpu_stall = bus.cpu_req && (grant == OWN_DMA);

  // Starvation counter: counts consecutive denied DMA cycles, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!bus.dma_req || bus.dma_gnt) begin
      wait_cnt <= '0;
    end else if (!dma_forced) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Response-owner FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) rsp_owner <= OWN_NONE;
    else       rsp_owner <= rsp_next;
  end

  // Response-owner FSM: next state follows the granted read, if any.
  always_comb begin
    rsp_next = OWN_NONE;
    case (grant)
      OWN_CPU: if (!bus.cpu_wren) rsp_next = OWN_CPU;
      OWN_DMA: if (!bus.dma_wren) rsp_next = OWN_DMA;
      default: ;
    endcase
  end

  // Response-owner FSM: outputs. A response still in flight when reset
  // arrives is dropped rather than delivered.
  always_comb begin
    bus.cpu_rvalid = (rsp_owner == OWN_CPU) && !reset;
    bus.dma_rvalid = (rsp_owner == OWN_DMA) && !reset;
    bus.cpu_rdata  = bus.q_dmem;
    bus.dma_rdata  = bus.q_dmem;
  end

  assign rsp_state = rsp_owner;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a default build with a dmem model
// and a MAX_WAIT=1 build for the alternation check.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int EXP_W  = DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- DUTs ----------------
  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b0 ();
  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();

  logic [2:0] w0;
  logic [1:0] s0;
  logic [0:0] w1;
  logic [1:0] s1;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) u0 (
    .clock     (clock),
    .reset     (reset),
    .bus       (b0),
    .wait_cnt  (w0),
    .rsp_state (s0)
  );

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(1)) u1 (
    .clock     (clock),
    .reset     (reset),
    .bus       (b1),
    .wait_cnt  (w1),
    .rsp_state (s1)
  );

  // ---------------- dmem model (registered read) ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h001] = 32'h11111111;
    mem[12'h002] = 32'h22222222;
  end

  always @(posedge clock) begin
    if (b0.wren_dmem) mem[b0.address_dmem] <= b0.data_dmem;
    b0.q_dmem <= mem[b0.address_dmem];
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entry = {owner_is_dma, data}
  task automatic push_rsp(input logic is_dma, input logic [DATA_W-1:0] d);
    exp_q.push_back({is_dma, d});
  endtask

  // Monitor: pops one expectation per presented response.
  always @(negedge clock) begin
    logic [EXP_W-1:0] e;
    if (b0.cpu_rvalid || b0.dma_rvalid) begin
      chk("rvalid_exclusive", {31'b0, b0.cpu_rvalid && b0.dma_rvalid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", {30'b0, b0.dma_rvalid, b0.cpu_rvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner", {31'b0, b0.dma_rvalid}, {31'b0, e[DATA_W]});
        chk("rsp_data", b0.dma_rvalid ? b0.dma_rdata : b0.cpu_rdata, e[DATA_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                        input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
    b0.cpu_req = cr; b0.cpu_wren = cw; b0.cpu_addr = ca; b0.cpu_wdata = cd;
    b0.dma_req = dr; b0.dma_wren = dw; b0.dma_addr = da; b0.dma_wdata = dd;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic exp_d;
    reset = 1'b1;
    b1.cpu_req = 1'b0; b1.cpu_wren = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 1'b0; b1.dma_wren = 1'b0; b1.dma_addr = '0; b1.dma_wdata = '0;
    b1.q_dmem = '0;
    // Requests (including writes) held during reset must be ignored.
    set_in(1'b1, 1'b1, 12'h3FF, 32'hFFFFFFFF, 1'b1, 1'b1, 12'h0AA, 32'h55555555);
    next_cycle(); #3;
    chk("reset_wren", {31'b0, b0.wren_dmem}, 32'd0);
    chk("reset_gnt", {31'b0, b0.dma_gnt}, 32'd0);
    chk("reset_stall", {31'b0, b0.cpu_stall}, 32'd0);
    chk("reset_wait", {29'b0, w0}, 32'd0);
    chk("reset_rsp_state", {30'b0, s0}, 32'd0);

    next_cycle(); reset = 1'b0; idle(); #3;
    chk("post_reset_cpu_rvalid", {31'b0, b0.cpu_rvalid}, 32'd0);
    chk("post_reset_dma_rvalid", {31'b0, b0.dma_rvalid}, 32'd0);

    // CPU-only load.
    next_cycle(); set_in(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0); #3;
    chk("cpu_only_stall", {31'b0, b0.cpu_stall}, 32'd0);
    chk("cpu_only_addr", {20'b0, b0.address_dmem}, 32'h010);
    chk("cpu_only_wren", {31'b0, b0.wren_dmem}, 32'd0);
    push_rsp(1'b0, 32'hDEADBEEF);
    next_cycle(); idle(); #3;

    // Contention: CPU x4, forced DMA, then CPU again.
    for (int k = 1; k <= 6; k++) begin
      next_cycle(); set_in(1'b1, 1'b0, 12'h001, '0, 1'b1, 1'b0, 12'h002, '0); #3;
      exp_d = (k == 5);
      chk("cont_wait", {29'b0, w0}, (k <= 5) ? 32'(k - 1) : 32'd0);
      chk("cont_gnt", {31'b0, b0.dma_gnt}, {31'b0, exp_d});
      chk("cont_stall", {31'b0, b0.cpu_stall}, {31'b0, exp_d});
      chk("cont_addr", {20'b0, b0.address_dmem}, exp_d ? 32'h002 : 32'h001);
      if (exp_d) push_rsp(1'b1, 32'h22222222);
      else       push_rsp(1'b0, 32'h11111111);
    end
    next_cycle(); idle(); #3;

    // DMA write, then CPU load of the same address.
    next_cycle(); set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h0FF, 32'h12345678); #3;
    chk("dma_wr_gnt", {31'b0, b0.dma_gnt}, 32'd1);
    chk("dma_wr_wren", {31'b0, b0.wren_dmem}, 32'd1);
    chk("dma_wr_addr", {20'b0, b0.address_dmem}, 32'h0FF);
    chk("dma_wr_data", b0.data_dmem, 32'h12345678);
    next_cycle(); set_in(1'b1, 1'b0, 12'h0FF, '0, 1'b0, 1'b0, '0, '0); #3;
    chk("wr_rd_stall", {31'b0, b0.cpu_stall}, 32'd0);
    push_rsp(1'b0, 32'h12345678);

    // CPU store then load back; DMA read of the earlier DMA write.
    next_cycle(); set_in(1'b1, 1'b1, 12'h020, 32'hA5A5A5A5, 1'b0, 1'b0, '0, '0); #3;
    chk("cpu_wr_wren", {31'b0, b0.wren_dmem}, 32'd1);
    chk("cpu_wr_data", b0.data_dmem, 32'hA5A5A5A5);
    next_cycle(); set_in(1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0); #3;
    push_rsp(1'b0, 32'hA5A5A5A5);
    next_cycle(); set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h0FF, '0); #3;
    chk("dma_rd_gnt", {31'b0, b0.dma_gnt}, 32'd1);
    push_rsp(1'b1, 32'h12345678);
    next_cycle(); idle(); #3;

    // Build up wait_cnt, then reset; the response in flight at reset is dropped.
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); set_in(1'b1, 1'b0, 12'h001, '0, 1'b1, 1'b0, 12'h002, '0); #3;
      chk("pre_rst_wait", {29'b0, w0}, 32'(k - 1));
      if (k < 3) push_rsp(1'b0, 32'h11111111);
    end
    next_cycle(); reset = 1'b1;
    set_in(1'b1, 1'b0, 12'h001, '0, 1'b1, 1'b1, 12'h002, 32'h99999999); #3;
    chk("rst1_gnt", {31'b0, b0.dma_gnt}, 32'd0);
    chk("rst1_stall", {31'b0, b0.cpu_stall}, 32'd0);
    chk("rst1_wren", {31'b0, b0.wren_dmem}, 32'd0);
    chk("rst1_cpu_rvalid", {31'b0, b0.cpu_rvalid}, 32'd0);
    next_cycle(); reset = 1'b0; set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h002, '0); #3;
    chk("rst1_wait_cleared", {29'b0, w0}, 32'd0);
    chk("rst2_dma_rd_gnt", {31'b0, b0.dma_gnt}, 32'd1);
    next_cycle(); reset = 1'b1;
    set_in(1'b1, 1'b1, 12'h030, 32'h0BADF00D, 1'b1, 1'b1, 12'h031, 32'h0BADBEEF); #3;
    chk("rst2_dma_rvalid", {31'b0, b0.dma_rvalid}, 32'd0);
    chk("rst2_wren", {31'b0, b0.wren_dmem}, 32'd0);
    chk("rst2_gnt", {31'b0, b0.dma_gnt}, 32'd0);
    chk("rst2_stall", {31'b0, b0.cpu_stall}, 32'd0);
    next_cycle(); reset = 1'b0; idle(); #3;
    chk("rst2_after_dma_rvalid", {31'b0, b0.dma_rvalid}, 32'd0);
    chk("rst2_after_wait", {29'b0, w0}, 32'd0);

    // MAX_WAIT=1 build: continuous contention alternates CPU/DMA.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      b1.cpu_req = 1'b1; b1.cpu_addr = 12'h004;
      b1.dma_req = 1'b1; b1.dma_addr = 12'h005;
      #3;
      chk("alt_gnt", {31'b0, b1.dma_gnt}, 32'(k % 2));
      chk("alt_stall", {31'b0, b1.cpu_stall}, 32'(k % 2));
    end
    next_cycle(); b1.cpu_req = 1'b0; b1.dma_req = 1'b0;

    next_cycle(); next_cycle(); #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
